// File: rtl/instr_mem_fetch.sv
// Loadable instruction memory with a registered 1-cycle fetch port.
// Words are loaded in boot mode; unwritten or faulting fetches return NOP_WORD.
module instr_mem_fetch #(
    parameter int unsigned      INS_ADDRESS = 9,
    parameter int unsigned      INS_W       = 32,
    parameter int unsigned      DEPTH       = 128,
    parameter logic [INS_W-1:0] NOP_WORD    = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       boot_en,
    input  logic                       prog_we,
    input  logic [INS_ADDRESS-1:0]     prog_addr,
    input  logic [INS_W-1:0]           prog_wdata,
    output logic                       prog_err,
    output logic [$clog2(DEPTH+1)-1:0] load_count,
    input  logic                       req_valid,
    input  logic [INS_ADDRESS-1:0]     req_addr,
    output logic                       req_ready,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [INS_W-1:0]           resp_data,
    output logic [INS_ADDRESS-1:0]     resp_addr,
    output logic [1:0]                 resp_fault
);

    localparam int unsigned IdxW  = INS_ADDRESS - 2;
    localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam logic [IdxW:0] DepthLim = (IdxW + 1)'(DEPTH);

    typedef enum logic {StEmpty, StFull} state_e;

    logic [INS_W-1:0]       mem [DEPTH];
    logic [DEPTH-1:0]       written_q;
    logic [CntW-1:0]        load_count_q;
    logic                   prog_err_q;
    state_e                 state_q;
    logic [INS_W-1:0]       resp_data_q;
    logic [INS_ADDRESS-1:0] resp_addr_q;
    logic [1:0]             resp_fault_q;

    logic [IdxW-1:0]  prog_idx, req_idx;
    logic [MemAw-1:0] prog_widx, req_widx;
    logic [1:0]       prog_flags, req_flags;
    logic             prog_hon, prog_ok, accept;
    logic [INS_W-1:0] fetch_data_d;

    assign prog_idx  = prog_addr[INS_ADDRESS-1:2];
    assign req_idx   = req_addr[INS_ADDRESS-1:2];
    assign prog_widx = prog_idx[MemAw-1:0];
    assign req_widx  = req_idx[MemAw-1:0];

    // bit0 misaligned, bit1 out of range
    assign prog_flags = {({1'b0, prog_idx} >= DepthLim), (prog_addr[1:0] != 2'b00)};
    assign req_flags  = {({1'b0, req_idx} >= DepthLim), (req_addr[1:0] != 2'b00)};

    assign prog_hon = boot_en & prog_we;
    assign prog_ok  = prog_hon & (prog_flags == 2'b00);

    assign resp_valid = (state_q == StFull);
    assign req_ready  = ~boot_en & (~resp_valid | resp_ready);
    assign accept     = req_valid & req_ready;

    always_comb begin
        fetch_data_d = NOP_WORD;
        if (req_flags == 2'b00 && written_q[req_widx]) begin
            fetch_data_d = mem[req_widx];
        end
    end

    // Array contents are deliberately not reset; written_q masks stale data.
    always_ff @(posedge clk) begin
        if (prog_ok) begin
            mem[prog_widx] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q    <= '0;
            load_count_q <= '0;
            prog_err_q   <= 1'b0;
        end else begin
            prog_err_q <= prog_hon & ~prog_ok;
            if (prog_ok) begin
                written_q[prog_widx] <= 1'b1;
                if (!written_q[prog_widx]) begin
                    load_count_q <= load_count_q + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            resp_data_q  <= NOP_WORD;
            resp_addr_q  <= '0;
            resp_fault_q <= 2'b00;
        end else begin
            unique case (state_q)
                StEmpty: if (accept) state_q <= StFull;
                StFull:  if (resp_ready && !accept) state_q <= StEmpty;
                default: state_q <= StEmpty;
            endcase
            if (accept) begin
                resp_data_q  <= fetch_data_d;
                resp_addr_q  <= req_addr;
                resp_fault_q <= req_flags;
            end
        end
    end

    assign prog_err   = prog_err_q;
    assign load_count = load_count_q;
    assign resp_data  = resp_data_q;
    assign resp_addr  = resp_addr_q;
    assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed and randomized checks of instr_mem_fetch (DEPTH=64) against a
// word-level reference model of the memory and response register.
module tb_instr_mem_fetch;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          boot_en, prog_we, prog_err;
    logic [AW-1:0] prog_addr, req_addr, resp_addr;
    logic [DW-1:0] prog_wdata, resp_data;
    logic [6:0]    load_count;
    logic          req_valid, req_ready, resp_valid, resp_ready;
    logic [1:0]    resp_fault;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model
    logic [31:0] m_mem [DEPTH];
    bit          m_wr  [DEPTH];
    int          m_cnt;
    bit          m_valid;
    logic [31:0] m_data;
    int          m_addr;
    logic [1:0]  m_fault;

    instr_mem_fetch #(
        .INS_ADDRESS(AW),
        .INS_W      (DW),
        .DEPTH      (DEPTH),
        .NOP_WORD   (NOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .boot_en   (boot_en),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_wdata(prog_wdata),
        .prog_err  (prog_err),
        .load_count(load_count),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_addr (resp_addr),
        .resp_fault(resp_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
        m_cnt   = 0;
        m_valid = 1'b0;
    endtask

    task automatic expect_fetch(input int a, output logic [31:0] d, output logic [1:0] f);
        f[0] = (a % 4) != 0;
        f[1] = (a / 4) >= DEPTH;
        d    = NOP;
        if (f == 2'b00) begin
            if (m_wr[a / 4]) d = m_mem[a / 4];
        end
    endtask

    task automatic boot_write(input int a, input logic [31:0] d);
        prog_we    = 1'b1;
        prog_addr  = AW'(a);
        prog_wdata = d;
        tick();
        prog_we = 1'b0;
    endtask

    logic [31:0] prog_img [4];
    logic [31:0] ed;
    logic [1:0]  ef;
    bit          exp_rdy, acc, hon, legal, exp_perr;
    int          pa, ra;

    initial begin
        prog_img[0] = 32'h00007033;
        prog_img[1] = 32'h00100093;
        prog_img[2] = 32'h00200113;
        prog_img[3] = 32'h00308193;
        rst_n = 1'b0; boot_en = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        #12 rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, NOP);
        chk("rst_resp_addr", resp_addr, 0);
        chk("rst_resp_fault", resp_fault, 0);
        chk("rst_prog_err", prog_err, 0);
        chk("rst_load_count", load_count, 0);
        chk("rst_req_ready", req_ready, 1);

        // Fetch of unwritten word 0
        req_valid = 1'b1; req_addr = 9'h000;
        tick();
        req_valid = 1'b0;
        chk("nop_valid", resp_valid, 1);
        chk("nop_data", resp_data, NOP);
        chk("nop_fault", resp_fault, 0);
        resp_ready = 1'b1;
        tick();
        chk("nop_consumed", resp_valid, 0);

        // Boot load, including one rewrite of word 1
        boot_en = 1'b1; req_valid = 1'b1; req_addr = 9'h000;
        #1 chk("boot_req_ready", req_ready, 0);
        for (int i = 0; i < 4; i++) boot_write(i * 4, prog_img[i]);
        boot_write(4, prog_img[1]);
        chk("boot_no_resp", resp_valid, 0);
        chk("boot_load_count", load_count, 4);
        boot_en = 1'b0; req_valid = 1'b0;

        // Back-to-back fetches
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_addr = AW'(i * 4);
            #1 chk("b2b_ready", req_ready, 1);
            tick();
            chk("b2b_valid", resp_valid, 1);
            chk("b2b_data", resp_data, prog_img[i]);
            chk("b2b_addr", resp_addr, i * 4);
        end
        req_valid = 1'b0;
        tick();
        chk("b2b_drain", resp_valid, 0);

        // Fault cases
        req_valid = 1'b1; req_addr = 9'h006;
        tick();
        chk("mis_fault", resp_fault, 2'b01);
        chk("mis_data", resp_data, NOP);
        req_addr = 9'h1FC;
        tick();
        chk("oor_fault", resp_fault, 2'b10);
        chk("oor_data", resp_data, NOP);
        req_valid = 1'b0;
        tick();
        boot_en = 1'b1;
        boot_write(9'h102, 32'hDEADBEEF);
        chk("perr_pulse", prog_err, 1);
        chk("perr_count", load_count, 4);
        tick();
        chk("perr_clear", prog_err, 0);
        boot_en = 1'b0;

        // Backpressure
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 9'h004;
        tick();
        req_addr = 9'h008;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_ready", req_ready, 0);
            chk("bp_data", resp_data, prog_img[1]);
            chk("bp_addr", resp_addr, 4);
            tick();
        end
        resp_ready = 1'b1;
        #1 chk("bp_release_ready", req_ready, 1);
        tick();
        chk("bp_next_addr", resp_addr, 8);
        chk("bp_next_data", resp_data, prog_img[2]);
        req_valid = 1'b0;
        tick();

        // boot_en raised while a response is pending
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 9'h00C;
        tick();
        boot_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1 chk("bootfull_ready", req_ready, 0);
            tick();
            chk("bootfull_held", resp_valid, 1);
            chk("bootfull_data", resp_data, prog_img[3]);
        end
        resp_ready = 1'b1;
        #1 chk("bootfull_ready_rr", req_ready, 0);
        tick();
        chk("bootfull_consumed", resp_valid, 0);
        boot_en = 1'b0;

        // Asynchronous reset while FULL
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 9'h000;
        tick();
        req_valid = 1'b0;
        chk("prerst_valid", resp_valid, 1);
        #2 rst_n = 1'b0;
        #1 chk("arst_valid", resp_valid, 0);
        chk("arst_count", load_count, 0);
        #1 rst_n = 1'b1;
        model_reset();
        req_valid = 1'b1; req_addr = 9'h000; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("postrst_valid", resp_valid, 1);
        chk("postrst_data", resp_data, NOP);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(15) == 0) boot_en = ~boot_en;
            prog_we    = $urandom_range(1);
            pa         = ($urandom_range(3) == 0) ? int'($urandom_range(511))
                                                  : int'($urandom_range(DEPTH - 1)) * 4;
            prog_addr  = AW'(pa);
            prog_wdata = $urandom;
            req_valid  = ($urandom_range(3) != 0);
            ra         = ($urandom_range(3) == 0) ? int'($urandom_range(511))
                                                  : int'($urandom_range(DEPTH - 1)) * 4;
            req_addr   = AW'(ra);
            resp_ready = ($urandom_range(2) != 0);
            #1;
            exp_rdy = !boot_en && (!m_valid || resp_ready);
            chk("rnd_req_ready", req_ready, exp_rdy);
            acc = req_valid && exp_rdy;
            expect_fetch(ra, ed, ef);
            tick();
            if (acc) begin
                m_valid = 1'b1; m_data = ed; m_addr = ra; m_fault = ef;
            end else if (resp_ready) begin
                m_valid = 1'b0;
            end
            hon      = boot_en && prog_we;
            legal    = (pa % 4 == 0) && (pa / 4 < DEPTH);
            exp_perr = hon && !legal;
            if (hon && legal) begin
                if (!m_wr[pa / 4]) m_cnt++;
                m_wr[pa / 4]  = 1'b1;
                m_mem[pa / 4] = prog_wdata;
            end
            chk("rnd_resp_valid", resp_valid, m_valid);
            if (m_valid) begin
                chk("rnd_resp_data", resp_data, m_data);
                chk("rnd_resp_addr", resp_addr, m_addr);
                chk("rnd_resp_fault", resp_fault, m_fault);
            end
            chk("rnd_prog_err", prog_err, exp_perr);
            chk("rnd_load_count", load_count, m_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
